ch_cyc_sched: RTL and testbench

- Cycle scheduler for the RH20 channel's shared control RAM and memory-buffer path.
- Arbitrates five requesters for one shared channel cycle: MB data, CCW RAM access, CBUS, controller register access and activity flag update.
- Sequences each granted cycle through T0..T3 timing and drives per-requester cycle grants to the channel control board.
- Replaces the ad hoc request/timing gating currently spread across the channel logic.

---
 rtl/ch_pkg.sv | 23 ++
 rtl/ch_cyc_arb.sv | 52 +++++
 rtl/ch_cyc_sched.sv | 200 ++++++++++++++++++++
 tb/tb_ch_cyc_sched.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ch_pkg.sv
// Shared types for the RH20 channel cycle scheduler.
// Requester index order doubles as the fixed priority order (MB highest).
package ch_pkg;

    localparam int NUM_REQ = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        T3   = 3'd4
    } cyc_state_t;

    typedef enum logic [2:0] {
        MB    = 3'd0,
        RAM   = 3'd1,
        CBUS  = 3'd2,
        CONTR = 3'd3,
        ACT   = 3'd4
    } req_idx_t;

endpackage

// File: rtl/ch_cyc_arb.sv
// Combinational requester pick for the channel cycle scheduler.
// One-hot grant, bit index = req_idx_t value.
// With CH_CYC_RR_EN defined, MB stays absolute; RAM..ACT rotate from ptr.
module ch_cyc_arb
    import ch_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
`ifdef CH_CYC_RR_EN
    input  logic [2:0]         ptr,
`endif
    output logic [NUM_REQ-1:0] gnt
);

`ifdef CH_CYC_RR_EN
    logic [1:0] base;
    logic [1:0] off;
    logic [2:0] idx;

    // MB first; otherwise scan the four rotating requesters starting at ptr
    always_comb begin
        gnt  = '0;
        base = (ptr == MB) ? 2'd0 : 2'(ptr - 3'd1);
        off  = 2'd0;
        idx  = 3'd0;
        if (req[MB]) begin
            gnt[MB] = 1'b1;
        end else begin
            // scan from lowest to highest precedence so the nearest one wins
            for (int k = 3; k >= 0; k--) begin
                off = base + 2'(k);
                idx = {1'b0, off} + 3'd1;
                if (req[idx]) begin
                    gnt      = '0;
                    gnt[idx] = 1'b1;
                end
            end
        end
    end
`else
    // Fixed priority: lowest index wins
    always_comb begin
        gnt = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/ch_cyc_sched.sv
// RH20 channel cycle scheduler: arbitrates five requesters for the shared
// control RAM / MB path and sequences each cycle through T0..T3.
// Optional build macro CH_CYC_RR_EN: round-robin among the non-MB requesters.
module ch_cyc_sched
    import ch_pkg::*;
#(
    parameter int TIMEOUT_CYC = 63,
    parameter int T1_WAIT     = 0
) (
    input  logic clk_ch_h,
    input  logic ch_mr_reset_l,
    input  logic ch_mb_req_h,
    input  logic ch_ram_req_h,
    input  logic ch_cbus_req_h,
    input  logic ch_contr_req_h,
    input  logic ch_act_flag_req_h,
    input  logic ch_mem_ack_h,
    input  logic ch_reset_intr_h,
    output logic ch_t0_h,
    output logic ch_t1_h,
    output logic ch_t2_h,
    output logic ch_t3_h,
    output logic crc_mb_cyc_h,
    output logic crc_ram_cyc_h,
    output logic crc_cbus_cyc_h,
    output logic crc_contr_cyc_h,
    output logic crc_act_cyc_h,
    output logic crc_cyc_done_h,
    output logic crc_mb_timeout_h,
    output logic crc_busy_h
);

    localparam int              TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [1:0]      T1W      = 2'(T1_WAIT);

    // phase bit order: [3]=T0 [2]=T1 [1]=T2 [0]=T3
    localparam logic [3:0] PH_NONE = 4'b0000;
    localparam logic [3:0] PH_T0   = 4'b1000;
    localparam logic [3:0] PH_T1   = 4'b0100;
    localparam logic [3:0] PH_T2   = 4'b0010;
    localparam logic [3:0] PH_T3   = 4'b0001;

    cyc_state_t         state;
    logic [3:0]         phase;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] pick;
    logic [1:0]         t1_cnt;
    logic [TW-1:0]      tmo_cnt;
    logic               aborted;
    logic               done;
    logic               timeout;
    logic               any_req;
    logic               arb_en;

    assign req_vec = {ch_act_flag_req_h, ch_contr_req_h, ch_cbus_req_h,
                      ch_ram_req_h, ch_mb_req_h};
    assign any_req = |req_vec;

    // Arbitration happens in IDLE, or in a T3 that was not reached by an abort
    assign arb_en = (state == IDLE) ||
                    ((state == T3) && !aborted && !ch_reset_intr_h);

`ifdef CH_CYC_RR_EN
    logic [2:0] ptr;
    logic [2:0] ptr_nxt;

    // Pointer moves to the entry after the winning non-MB requester
    always_comb begin
        ptr_nxt = ptr;
        if (pick[RAM])   ptr_nxt = CBUS;
        if (pick[CBUS])  ptr_nxt = CONTR;
        if (pick[CONTR]) ptr_nxt = ACT;
        if (pick[ACT])   ptr_nxt = RAM;
    end

    // Round-robin pointer register, updated only when a cycle is granted
    always_ff @(posedge clk_ch_h or negedge ch_mr_reset_l) begin
        if (!ch_mr_reset_l) begin
            ptr <= MB;
        end else if (arb_en && any_req) begin
            ptr <= ptr_nxt;
        end
    end
`endif

    ch_cyc_arb u_arb (
        .req (req_vec),
`ifdef CH_CYC_RR_EN
        .ptr (ptr),
`endif
        .gnt (pick)
    );

    // Cycle FSM with registered phase, grant, done and timeout outputs
    always_ff @(posedge clk_ch_h or negedge ch_mr_reset_l) begin
        if (!ch_mr_reset_l) begin
            state   <= IDLE;
            phase   <= PH_NONE;
            grant   <= '0;
            done    <= 1'b0;
            timeout <= 1'b0;
            aborted <= 1'b0;
            t1_cnt  <= '0;
            tmo_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (ch_reset_intr_h) begin
                timeout <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= T0;
                        phase <= PH_T0;
                        grant <= pick;
                    end
                end
                T0: begin
                    if (ch_reset_intr_h) begin
                        state   <= T3;
                        phase   <= PH_T3;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else begin
                        state  <= T1;
                        phase  <= PH_T1;
                        t1_cnt <= '0;
                    end
                end
                T1: begin
                    if (ch_reset_intr_h) begin
                        state   <= T3;
                        phase   <= PH_T3;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (t1_cnt == T1W) begin
                        state   <= T2;
                        phase   <= PH_T2;
                        tmo_cnt <= '0;
                    end else begin
                        t1_cnt <= t1_cnt + 2'd1;
                    end
                end
                T2: begin
                    // abort beats a coincident memory acknowledge
                    if (ch_reset_intr_h) begin
                        state   <= T3;
                        phase   <= PH_T3;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (!grant[MB] || ch_mem_ack_h) begin
                        state <= T3;
                        phase <= PH_T3;
                        done  <= 1'b1;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state   <= T3;
                        phase   <= PH_T3;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                T3: begin
                    aborted <= 1'b0;
                    if (arb_en && any_req) begin
                        state <= T0;
                        phase <= PH_T0;
                        grant <= pick;
                    end else begin
                        state <= IDLE;
                        phase <= PH_NONE;
                        grant <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    phase <= PH_NONE;
                    grant <= '0;
                end
            endcase
        end
    end

    assign ch_t0_h          = phase[3];
    assign ch_t1_h          = phase[2];
    assign ch_t2_h          = phase[1];
    assign ch_t3_h          = phase[0];
    assign crc_mb_cyc_h     = grant[MB];
    assign crc_ram_cyc_h    = grant[RAM];
    assign crc_cbus_cyc_h   = grant[CBUS];
    assign crc_contr_cyc_h  = grant[CONTR];
    assign crc_act_cyc_h    = grant[ACT];
    assign crc_cyc_done_h   = done;
    assign crc_mb_timeout_h = timeout;
    assign crc_busy_h       = |phase;

endmodule

// File: tb/tb_ch_cyc_sched.sv
// Self-checking bench for ch_cyc_sched: directed scenarios plus a randomized
// run against a cycle-level reference model. Honours CH_CYC_RR_EN if defined.
module tb_ch_cyc_sched;

    localparam int TMO = 63;
    localparam int T1W = 0;

    logic clk = 1'b0;
    logic rst_n;
    logic mb_req, ram_req, cbus_req, contr_req, act_req;
    logic mem_ack, reset_intr;
    logic t0, t1, t2, t3;
    logic g_mb, g_ram, g_cbus, g_contr, g_act;
    logic done, timeout, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ch_cyc_sched #(.TIMEOUT_CYC(TMO), .T1_WAIT(T1W)) dut (
        .clk_ch_h          (clk),
        .ch_mr_reset_l     (rst_n),
        .ch_mb_req_h       (mb_req),
        .ch_ram_req_h      (ram_req),
        .ch_cbus_req_h     (cbus_req),
        .ch_contr_req_h    (contr_req),
        .ch_act_flag_req_h (act_req),
        .ch_mem_ack_h      (mem_ack),
        .ch_reset_intr_h   (reset_intr),
        .ch_t0_h           (t0),
        .ch_t1_h           (t1),
        .ch_t2_h           (t2),
        .ch_t3_h           (t3),
        .crc_mb_cyc_h      (g_mb),
        .crc_ram_cyc_h     (g_ram),
        .crc_cbus_cyc_h    (g_cbus),
        .crc_contr_cyc_h   (g_contr),
        .crc_act_cyc_h     (g_act),
        .crc_cyc_done_h    (done),
        .crc_mb_timeout_h  (timeout),
        .crc_busy_h        (busy)
    );

    function automatic logic [3:0] ph();
        return {t0, t1, t2, t3};
    endfunction

    function automatic logic [4:0] gv();
        return {g_act, g_contr, g_cbus, g_ram, g_mb};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [4:0] r);
        {act_req, contr_req, cbus_req, ram_req, mb_req} = r;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300 && busy; i++) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_wait: busy=%b required 0", name, busy);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_req(5'b11111);
        mem_ack = 1'b0;
        reset_intr = 1'b0;
        rst_n = 1'b0;
        #1;
        tick();
        checks++;
        if ({ph(), gv(), done, busy, timeout} !== 12'h0) begin
            errors++;
            $display("FAIL reset_outputs: phase=%b grant=%b done=%b busy=%b tmo=%b required all 0",
                     ph(), gv(), done, busy, timeout);
        end
        set_req(5'b00000);
        rst_n = 1'b1;
        tick();
        checks++;
        if ({ph(), busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_release_idle: phase=%b busy=%b required 0", ph(), busy);
        end
    endtask

    task automatic test_cbus_only();
        logic [3:0] exp_ph[6] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b0000};
        int gcnt = 0;
        int dcnt = 0;
        set_req(5'b00100);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) set_req(5'b00000);
            gcnt += int'(g_cbus);
            dcnt += int'(done);
            checks++;
            if (ph() !== exp_ph[i]) begin
                errors++;
                $display("FAIL cbus_phase[%0d]: got %b required %b", i, ph(), exp_ph[i]);
            end
            checks++;
            if ((gv() & ~5'b00100) !== 5'b0) begin
                errors++;
                $display("FAIL cbus_other_grant[%0d]: got %b required 00000", i, gv());
            end
        end
        checks++;
        if (gcnt != 4) begin
            errors++;
            $display("FAIL cbus_grant_len: got %0d required 4", gcnt);
        end
        checks++;
        if (dcnt != 1) begin
            errors++;
            $display("FAIL cbus_done_pulses: got %0d required 1", dcnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL cbus_end_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_mb_act();
        set_req(5'b10001);
        mem_ack = 1'b1;
        tick();
        checks++;
        if ({ph(), gv()} !== {4'b1000, 5'b00001}) begin
            errors++;
            $display("FAIL mbact_first: phase=%b grant=%b required 1000/00001", ph(), gv());
        end
        set_req(5'b10000);
        tick();
        tick();
        tick();
        checks++;
        if ({ph(), gv(), done} !== {4'b0001, 5'b00001, 1'b1}) begin
            errors++;
            $display("FAIL mbact_mb_t3: phase=%b grant=%b done=%b required 0001/00001/1",
                     ph(), gv(), done);
        end
        tick();
        checks++;
        if ({ph(), gv(), busy} !== {4'b1000, 5'b10000, 1'b1}) begin
            errors++;
            $display("FAIL mbact_b2b: phase=%b grant=%b busy=%b required 1000/10000/1",
                     ph(), gv(), busy);
        end
        set_req(5'b00000);
        mem_ack = 1'b0;
        wait_idle("mbact");
    endtask

    task automatic test_mb_ack10();
        int n2 = 0;
        int tot = 0;
        set_req(5'b00001);
        mem_ack = 1'b0;
        tick();
        set_req(5'b00000);
        tot = 1;
        for (int i = 0; i < 200 && busy; i++) begin
            tick();
            if (busy) tot++;
            if (t2) n2++;
            mem_ack = (t2 && n2 == 10);
        end
        mem_ack = 1'b0;
        checks++;
        if (n2 != 10) begin
            errors++;
            $display("FAIL ack10_t2_len: got %0d required 10", n2);
        end
        checks++;
        if (tot != 13) begin
            errors++;
            $display("FAIL ack10_cycle_len: got %0d required 13", tot);
        end
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL ack10_timeout: got %b required 0", timeout);
        end
    endtask

    task automatic test_mb_timeout();
        int n2 = 0;
        int early = 0;
        logic at_t3 = 1'b0;
        set_req(5'b00001);
        mem_ack = 1'b0;
        tick();
        set_req(5'b00000);
        for (int i = 0; i < 200 && !t3; i++) begin
            tick();
            if (t2) begin
                n2++;
                if (timeout) early++;
            end
        end
        at_t3 = t3;
        checks++;
        if (n2 != TMO) begin
            errors++;
            $display("FAIL tmo_t2_len: got %0d required %0d", n2, TMO);
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL tmo_early: flag seen in %0d T2 clocks required 0", early);
        end
        checks++;
        if ({at_t3, timeout} !== 2'b11) begin
            errors++;
            $display("FAIL tmo_set_at_t3: t3=%b tmo=%b required 1/1", at_t3, timeout);
        end
        wait_idle("tmo");
        set_req(5'b00100);
        tick();
        set_req(5'b00000);
        wait_idle("tmo_cbus");
        checks++;
        if (timeout !== 1'b1) begin
            errors++;
            $display("FAIL tmo_sticky: got %b required 1", timeout);
        end
        reset_intr = 1'b1;
        tick();
        reset_intr = 1'b0;
        checks++;
        if ({timeout, busy} !== 2'b00) begin
            errors++;
            $display("FAIL tmo_intr_clear: tmo=%b busy=%b required 0/0", timeout, busy);
        end
    endtask

    task automatic test_intr_t1();
        set_req(5'b00110);
        tick();
        tick();
        checks++;
        if ({ph(), gv()} !== {4'b0100, 5'b00010}) begin
            errors++;
            $display("FAIL intr_pre: phase=%b grant=%b required 0100/00010", ph(), gv());
        end
        reset_intr = 1'b1;
        tick();
        reset_intr = 1'b0;
        checks++;
        if ({ph(), gv(), done} !== {4'b0001, 5'b00010, 1'b1}) begin
            errors++;
            $display("FAIL intr_t3: phase=%b grant=%b done=%b required 0001/00010/1",
                     ph(), gv(), done);
        end
        tick();
        set_req(5'b00000);
        checks++;
        if ({ph(), gv(), busy} !== 10'b0) begin
            errors++;
            $display("FAIL intr_idle: phase=%b grant=%b busy=%b required 0", ph(), gv(), busy);
        end
    endtask

    task automatic test_async_reset();
        set_req(5'b00001);
        mem_ack = 1'b0;
        tick();
        set_req(5'b00100);
        tick();
        tick();
        checks++;
        if (ph() !== 4'b0010) begin
            errors++;
            $display("FAIL arst_pre_t2: phase=%b required 0010", ph());
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ph(), gv(), done, busy, timeout} !== 12'h0) begin
            errors++;
            $display("FAIL arst_async: phase=%b grant=%b done=%b busy=%b required 0",
                     ph(), gv(), done, busy);
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL arst_hold: done=%b busy=%b required 0/0", done, busy);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({ph(), gv()} !== {4'b1000, 5'b00100}) begin
            errors++;
            $display("FAIL arst_rearb: phase=%b grant=%b required 1000/00100", ph(), gv());
        end
        set_req(5'b00000);
        wait_idle("arst");
    endtask

    task automatic test_rr();
        logic [4:0] got[4];
        logic [4:0] exp[4];
        int n = 0;
`ifdef CH_CYC_RR_EN
        exp = '{5'b00010, 5'b00100, 5'b01000, 5'b00010};
`else
        exp = '{5'b00010, 5'b00010, 5'b00010, 5'b00010};
`endif
        for (int k = 0; k < 4; k++) got[k] = 5'b0;
        do_reset();
        set_req(5'b01110);
        for (int i = 0; i < 40 && n < 4; i++) begin
            tick();
            if (t0) begin
                got[n] = gv();
                n++;
            end
        end
        set_req(5'b00000);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] !== exp[k]) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b required %b", k, got[k], exp[k]);
            end
        end
        wait_idle("rr");
    endtask

    // Winner from the requester set: MB absolute, then the rest in priority
    // order (fixed) or starting from the rotation position (round-robin).
    function automatic int model_pick(input logic [4:0] r, input int ptr);
        int s;
        s = (ptr == 0) ? 1 : ptr;
        if (r[0]) return 0;
`ifdef CH_CYC_RR_EN
        for (int k = 0; k < 4; k++) if (r[1 + ((s - 1 + k) % 4)]) return 1 + ((s - 1 + k) % 4);
`else
        if (s < 0) return -1;
        for (int i = 1; i < 5; i++) if (r[i]) return i;
`endif
        return -1;
    endfunction

    task automatic test_random();
        int p = 0;          // 0 idle, 1..4 = T0..T3
        int own = -1;
        int t1c = 0;
        int t2c = 0;
        int ptr = 0;
        int mode = 0;
        bit ab = 0;
        bit tmo = 0;
        bit dn = 0;
        logic [4:0] r = 5'b0;
        logic [3:0] eph;
        logic [4:0] eg;
        set_req(5'b0);
        mem_ack = 1'b0;
        reset_intr = 1'b0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) mode = $urandom_range(0, 2);
            if ($urandom_range(0, 5) == 0) r = 5'($urandom);
            set_req(r);
            mem_ack = (mode == 2) ? 1'b0 : ($urandom_range(0, 2) == 0);
            reset_intr = ($urandom_range(0, 49) == 0);
            dn = 0;
            if (reset_intr) tmo = 0;
            case (p)
                0: if (r != 0) begin
                       own = model_pick(r, ptr);
                       if (own > 0) ptr = (own == 4) ? 1 : own + 1;
                       p = 1;
                   end
                1: if (reset_intr) begin p = 4; ab = 1; dn = 1; end
                   else begin p = 2; t1c = 0; end
                2: if (reset_intr) begin p = 4; ab = 1; dn = 1; end
                   else if (t1c == T1W) begin p = 3; t2c = 0; end
                   else t1c++;
                3: if (reset_intr) begin p = 4; ab = 1; dn = 1; end
                   else begin
                       t2c++;
                       if (own != 0 || mem_ack) begin p = 4; dn = 1; end
                       else if (t2c >= TMO) begin p = 4; dn = 1; tmo = 1; end
                   end
                default: begin
                    if (!ab && !reset_intr && r != 0) begin
                        own = model_pick(r, ptr);
                        if (own > 0) ptr = (own == 4) ? 1 : own + 1;
                        p = 1;
                    end else begin
                        p = 0;
                        own = -1;
                    end
                    ab = 0;
                end
            endcase
            tick();
            eph = (p == 0) ? 4'b0 : 4'(8 >> (p - 1));
            eg  = (own >= 0) ? 5'(1 << own) : 5'b0;
            checks++;
            if ({ph(), gv(), done, busy, timeout} !== {eph, eg, dn, (p != 0), tmo}) begin
                errors++;
                $display("FAIL rand[%0d]: phase=%b grant=%b done=%b busy=%b tmo=%b required %b/%b/%b/%b/%b",
                         c, ph(), gv(), done, busy, timeout, eph, eg, dn, (p != 0), tmo);
            end
        end
        set_req(5'b0);
        mem_ack = 1'b0;
        reset_intr = 1'b0;
        wait_idle("rand");
    endtask

    initial begin
        rst_n = 1'b0;
        set_req(5'b0);
        mem_ack = 1'b0;
        reset_intr = 1'b0;
        test_reset();
        test_cbus_only();
        test_mb_act();
        test_mb_ack10();
        test_mb_timeout();
        test_intr_t1();
        test_async_reset();
        test_rr();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
